// File: rtl/apb_regbank_pkg.sv
// Shared types, widths and address-map helpers for the APB register-bank slave.
package apb_regbank_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Word-index layout: CTRL[0..NUM_RW-1], STATUS[..], INT_EN, INT_PEND.
  function automatic int status_base(input int num_rw);
    return num_rw;
  endfunction

  function automatic int int_en_idx(input int num_rw, input int num_ro);
    return num_rw + num_ro;
  endfunction

  function automatic int int_pend_idx(input int num_rw, input int num_ro);
    return num_rw + num_ro + 1;
  endfunction

  function automatic logic [DATA_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] mask;
    for (int b = 0; b < STRB_W; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/apb_access_fsm.sv
// APB IDLE/ACCESS sequencer with a programmable wait-state counter.
module apb_access_fsm
  import apb_regbank_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic psel_i,
  input  logic penable_i,
  output logic pready_o,
  output logic commit_o
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  apb_state_e state_q;
  logic [3:0] cnt_q;
  logic       pready_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psel_i && !penable_i) begin
            state_q  <= ACCESS;
            cnt_q    <= WAIT_CNT;
            pready_q <= (WAIT_CNT == 4'd0);
          end
        end
        ACCESS: begin
          // An aborted transfer (PSEL dropped) returns without completing.
          if (!psel_i || cnt_q == 4'd0) begin
            state_q  <= IDLE;
            pready_q <= 1'b0;
          end else begin
            cnt_q    <= cnt_q - 4'd1;
            pready_q <= (cnt_q == 4'd1);
          end
        end
        default: begin
          state_q  <= IDLE;
          pready_q <= 1'b0;
        end
      endcase
    end
  end

  assign pready_o = pready_q;
  assign commit_o = pready_q & psel_i & penable_i;

endmodule

// File: rtl/apb_regbank_slave.sv
// Parametrised APB4 register bank: RW control, RO status shadows, IRQ enable/pending.
module apb_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int NUM_RW      = 4,
  parameter int NUM_RO      = 2,
  parameter int IRQ_W       = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [ADDR_W-1:0]        PADDR,
  input  logic                     PWRITE,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [DATA_W-1:0]        PWDATA,
  input  logic [STRB_W-1:0]        PSTRB,
  output logic [DATA_W-1:0]        PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [NUM_RW*DATA_W-1:0] ctrl_o,
  input  logic [NUM_RO*DATA_W-1:0] status_i,
  input  logic [IRQ_W-1:0]         event_i,
  output logic                     irq_o
);

  localparam int STATUS_IDX = status_base(NUM_RW);
  localparam int EN_IDX     = int_en_idx(NUM_RW, NUM_RO);
  localparam int PEND_IDX   = int_pend_idx(NUM_RW, NUM_RO);

  if (NUM_RW + NUM_RO + 2 > 2 ** (ADDR_W - 2)) begin : g_map_too_small
    $error("apb_regbank_slave: register map does not fit in ADDR_W");
  end
  if (IRQ_W < 1 || IRQ_W > 32) begin : g_bad_irq_w
    $error("apb_regbank_slave: IRQ_W must be 1..32");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("apb_regbank_slave: WAIT_STATES must be 0..15");
  end

  logic pready, commit;

  apb_access_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .psel_i    (PSEL),
    .penable_i (PENABLE),
    .pready_o  (pready),
    .commit_o  (commit)
  );

  logic [DATA_W-1:0] ctrl_q   [NUM_RW];
  logic [DATA_W-1:0] ctrl_d   [NUM_RW];
  logic [DATA_W-1:0] status_q [NUM_RO];
  logic [IRQ_W-1:0]  en_q, en_d;
  logic [IRQ_W-1:0]  pend_q, pend_d;
  logic              irq_q, irq_d;

  int                widx;
  logic              hit_ctrl, hit_status, hit_en, hit_pend, unmapped;
  logic              access_err, wr_ok;
  logic [DATA_W-1:0] mask, rdata;
  logic [IRQ_W-1:0]  clr;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    widx       = int'(PADDR[ADDR_W-1:2]);
    hit_ctrl   = (widx < NUM_RW);
    hit_status = (widx >= STATUS_IDX) && (widx < EN_IDX);
    hit_en     = (widx == EN_IDX);
    hit_pend   = (widx == PEND_IDX);
    unmapped   = !(hit_ctrl || hit_status || hit_en || hit_pend);
    access_err = PWRITE ? (hit_status || unmapped) : unmapped;
    wr_ok      = commit && PWRITE && !access_err;
    mask       = strb_to_mask(PSTRB);
  end

  always_comb begin
    for (int k = 0; k < NUM_RW; k++) begin
      ctrl_d[k] = ctrl_q[k];
      if (wr_ok && widx == k) begin
        ctrl_d[k] = (ctrl_q[k] & ~mask) | (PWDATA & mask);
      end
    end
    en_d = en_q;
    if (wr_ok && hit_en) begin
      en_d = (en_q & ~mask[IRQ_W-1:0]) | (PWDATA[IRQ_W-1:0] & mask[IRQ_W-1:0]);
    end
    clr = '0;
    if (wr_ok && hit_pend) begin
      clr = PWDATA[IRQ_W-1:0] & mask[IRQ_W-1:0];
    end
    // OR-ing events after the clear makes a same-cycle event win over W1C.
    pend_d = (pend_q & ~clr) | event_i;
    irq_d  = |(pend_q & en_q);
  end

  // NOTE: the register arrays are reset explicitly; software relies on known-zero controls.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int k = 0; k < NUM_RW; k++) ctrl_q[k] <= '0;
      for (int j = 0; j < NUM_RO; j++) status_q[j] <= '0;
      en_q   <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_RW; k++) ctrl_q[k] <= ctrl_d[k];
      for (int j = 0; j < NUM_RO; j++) status_q[j] <= status_i[DATA_W*j +: DATA_W];
      en_q   <= en_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (widx == k) rdata = ctrl_q[k];
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (widx == STATUS_IDX + j) rdata = status_q[j];
    end
    if (hit_en)   rdata[IRQ_W-1:0] = en_q;
    if (hit_pend) rdata[IRQ_W-1:0] = pend_q;
  end

  always_comb begin
    for (int k = 0; k < NUM_RW; k++) begin
      ctrl_o[DATA_W*k +: DATA_W] = ctrl_q[k];
    end
  end

  assign PREADY  = pready;
  assign PSLVERR = pready && PSEL && access_err;
  assign PRDATA  = (pready && PSEL && !PWRITE && !access_err) ? rdata : '0;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Scoreboard bench: three slave instances (0, 3 and 2 wait states) on a shared APB bus.
module tb_apb_regbank_slave;

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic [5:0]   paddr = '0;
  logic         pwrite = 1'b0;
  logic [2:0]   psel = '0;
  logic         penable = 1'b0;
  logic [31:0]  pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic [63:0]  status_in = '0;
  logic [7:0]   event_in = '0;

  logic [31:0]  prdata  [3];
  logic         pready  [3];
  logic         pslverr [3];
  logic [127:0] ctrl    [3];
  logic         irq     [3];

  always #5 PCLK = ~PCLK;

  apb_regbank_slave #(.WAIT_STATES(0)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel[0]),
    .PENABLE(penable), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0]), .ctrl_o(ctrl[0]), .status_i(status_in),
    .event_i(event_in), .irq_o(irq[0])
  );
  apb_regbank_slave #(.WAIT_STATES(3)) u_dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel[1]),
    .PENABLE(penable), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1]), .ctrl_o(ctrl[1]), .status_i(status_in),
    .event_i(event_in), .irq_o(irq[1])
  );
  apb_regbank_slave #(.WAIT_STATES(2)) u_dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel[2]),
    .PENABLE(penable), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[2]),
    .PREADY(pready[2]), .PSLVERR(pslverr[2]), .ctrl_o(ctrl[2]), .status_i(status_in),
    .event_i(event_in), .irq_o(irq[2])
  );

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   waits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_ctrl(input int d, input string name, input logic [127:0] exp);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_ctrl%0d", name, k), ctrl[d][32*k +: 32], exp[32*k +: 32]);
    end
  endtask

  // Monitor: pops one expected response per completed transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      for (int d = 0; d < 3; d++) begin
        if (psel[d] && penable && pready[d]) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_response: dut %0d responded with no expectation", d);
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_dut"}, 32'(d), 32'(e.dut));
            check({e.name, "_prdata"}, prdata[d], e.rdata);
            check({e.name, "_pslverr"}, 32'(pslverr[d]), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic apb_xfer(input int d, input logic wr, input logic [5:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input string name, output int nwait);
    exp_t e;
    bit   done;
    e.dut = d; e.rdata = exp_rdata; e.err = exp_err; e.name = name;
    sb_q.push_back(e);
    @(posedge PCLK); #1;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge PCLK); #1;
    penable = 1'b1;
    nwait = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      if (pready[d]) done = 1'b1;
      else nwait++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: PREADY never rose, expected within 40 cycles", name);
      void'(sb_q.pop_back());
    end
    @(posedge PCLK); #1;
    psel[d] = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input int d, input logic [5:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic err, input string name);
    int w;
    apb_xfer(d, 1'b1, addr, data, strb, 32'h0, err, name, w);
  endtask

  task automatic rd(input int d, input logic [5:0] addr, input logic [31:0] exp,
                    input logic err, input string name);
    int w;
    apb_xfer(d, 1'b0, addr, 32'h0, 4'h0, exp, err, name, w);
  endtask

  task automatic pulse_event(input int bit_idx);
    @(posedge PCLK); #1;
    event_in[bit_idx] = 1'b1;
    @(posedge PCLK); #1;
    event_in = '0;
  endtask

  initial begin
    status_in = {32'hCAFE0001, 32'h5A5A0000};

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_pready%0d", d), 32'(pready[d]), 32'h0);
      check($sformatf("rst_pslverr%0d", d), 32'(pslverr[d]), 32'h0);
      check($sformatf("rst_prdata%0d", d), prdata[d], 32'h0);
      check($sformatf("rst_irq%0d", d), 32'(irq[d]), 32'h0);
    end
    check_ctrl(0, "rst", 128'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Zero-wait write/read
    wr(0, 6'h04, 32'hDEADBEEF, 4'hF, 1'b0, "wr_ctrl1");
    check_ctrl(0, "after_ctrl1", {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
    apb_xfer(0, 1'b0, 6'h04, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "rd_ctrl1", waits);
    check("zero_wait_count", 32'(waits), 32'd0);

    // Byte strobes
    wr(0, 6'h00, 32'h11223344, 4'hF, 1'b0, "wr_ctrl0_full");
    wr(0, 6'h00, 32'hAABBCCDD, 4'h5, 1'b0, "wr_ctrl0_strb5");
    rd(0, 6'h00, 32'h11BB33DD, 1'b0, "rd_ctrl0_strb");
    wr(0, 6'h08, 32'hFFFFFFFF, 4'h0, 1'b0, "wr_ctrl2_nostrb");
    rd(0, 6'h08, 32'h0, 1'b0, "rd_ctrl2_nostrb");
    check_ctrl(0, "strb", {32'h0, 32'h0, 32'hDEADBEEF, 32'h11BB33DD});

    // Status shadows and errors
    rd(0, 6'h10, 32'h5A5A0000, 1'b0, "rd_status0");
    rd(0, 6'h14, 32'hCAFE0001, 1'b0, "rd_status1");
    wr(0, 6'h10, 32'h12345678, 4'hF, 1'b1, "wr_status_err");
    rd(0, 6'h10, 32'h5A5A0000, 1'b0, "rd_status0_after");
    rd(0, 6'h3C, 32'h0, 1'b1, "rd_unmapped");
    wr(0, 6'h3C, 32'hFFFFFFFF, 4'hF, 1'b1, "wr_unmapped");
    rd(0, 6'h20, 32'h0, 1'b1, "rd_unmapped_lo");
    check_ctrl(0, "err", {32'h0, 32'h0, 32'hDEADBEEF, 32'h11BB33DD});
    rd(0, 6'h18, 32'h0, 1'b0, "rd_en_clean");
    rd(0, 6'h1C, 32'h0, 1'b0, "rd_pend_clean");

    // Interrupts
    wr(0, 6'h18, 32'h00000001, 4'hF, 1'b0, "wr_en1");
    check("irq_idle", 32'(irq[0]), 32'h0);
    @(posedge PCLK); #1;
    event_in[0] = 1'b1;
    @(posedge PCLK); #1;
    event_in = '0;
    check("irq_same_edge", 32'(irq[0]), 32'h0);
    @(posedge PCLK); #1;
    check("irq_rise", 32'(irq[0]), 32'h1);
    rd(0, 6'h1C, 32'h01, 1'b0, "rd_pend_set");
    wr(0, 6'h18, 32'hFFFFFFFF, 4'hF, 1'b0, "wr_en_all");
    rd(0, 6'h18, 32'h000000FF, 1'b0, "rd_en_masked");
    wr(0, 6'h18, 32'h00000001, 4'hF, 1'b0, "wr_en1_again");

    fork
      wr(0, 6'h1C, 32'h00000001, 4'hF, 1'b0, "w1c_with_event");
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge PCLK);
          if (psel[0] && penable && pready[0]) break;
        end
        event_in[0] = 1'b1;
        @(posedge PCLK); #1;
        event_in = '0;
      end
    join
    check("irq_set_wins_0", 32'(irq[0]), 32'h1);
    @(posedge PCLK); #1;
    check("irq_set_wins_1", 32'(irq[0]), 32'h1);
    rd(0, 6'h1C, 32'h01, 1'b0, "rd_pend_set_wins");

    wr(0, 6'h1C, 32'h00000001, 4'hF, 1'b0, "w1c_clear");
    check("irq_at_commit", 32'(irq[0]), 32'h1);
    @(posedge PCLK); #1;
    check("irq_fall", 32'(irq[0]), 32'h0);
    rd(0, 6'h1C, 32'h0, 1'b0, "rd_pend_clear");

    pulse_event(3);
    repeat (2) @(posedge PCLK);
    #1;
    check("irq_masked", 32'(irq[0]), 32'h0);
    rd(0, 6'h1C, 32'h08, 1'b0, "rd_pend_bit3");

    // Wait states on the 3-wait instance
    wr(1, 6'h04, 32'h00001234, 4'hF, 1'b0, "ws3_wr_ctrl1");
    apb_xfer(1, 1'b0, 6'h04, 32'h0, 4'h0, 32'h00001234, 1'b0, "ws3_rd_ctrl1", waits);
    check("ws3_wait_count", 32'(waits), 32'd3);

    // Aborted write: PSEL drops in the second access cycle
    @(posedge PCLK); #1;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h04;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    psel[1] = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (5) @(posedge PCLK);
    #1;
    check_ctrl(1, "abort", {32'h0, 32'h0, 32'h00001234, 32'h0});
    rd(1, 6'h04, 32'h00001234, 1'b0, "ws3_rd_after_abort");

    // Reset in the middle of a 2-wait access
    wr(2, 6'h00, 32'hA5A5A5A5, 4'hF, 1'b0, "ws2_wr_ctrl0");
    wr(2, 6'h18, 32'h00000001, 4'hF, 1'b0, "ws2_wr_en");
    pulse_event(0);
    @(posedge PCLK); #1;
    check("ws2_irq_before_rst", 32'(irq[2]), 32'h1);
    @(posedge PCLK); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h04;
    pwdata = 32'h00000077; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    check("ws2_pready_wait", 32'(pready[2]), 32'h0);
    #1;
    PRESETn = 1'b0;
    #1;
    check("midrst_pready", 32'(pready[2]), 32'h0);
    check("midrst_irq2", 32'(irq[2]), 32'h0);
    check("midrst_irq0", 32'(irq[0]), 32'h0);
    check_ctrl(2, "midrst2", 128'h0);
    check_ctrl(0, "midrst0", 128'h0);
    @(posedge PCLK); #1;
    psel[2] = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    apb_xfer(2, 1'b1, 6'h04, 32'h00000077, 4'hF, 32'h0, 1'b0, "ws2_wr_after_rst", waits);
    check("ws2_wait_count", 32'(waits), 32'd2);
    rd(2, 6'h04, 32'h00000077, 1'b0, "ws2_rd_ctrl1");
    rd(2, 6'h00, 32'h0, 1'b0, "ws2_rd_ctrl0_cleared");
    check_ctrl(2, "post_rst", {32'h0, 32'h0, 32'h00000077, 32'h0});

    repeat (2) @(posedge PCLK);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at 200000 time units, expected to finish earlier");
    $fatal(1, "timeout");
  end

endmodule
